// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_req_tracker.sv
// Pending-call register plus above/below reduction relative to the car position.
module elevator_req_tracker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_req,
  input  logic [FW-1:0]         current_floor,
  input  logic                  clr_en,
  input  logic [FW-1:0]         clr_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] req_eff,
  output logic                  above,
  output logic                  below
);

  logic [NUM_FLOORS-1:0] clr_mask;

  assign req_eff = pending | floor_req;

  // One-hot mask of the call being served (or suppressed) this edge
  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      clr_mask[i] = clr_en && (clr_floor == FW'(i));
    end
  end

  // Latch new calls, drop the one served on this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= req_eff & ~clr_mask;
    end
  end

  // Any call strictly above / strictly below the current floor
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (req_eff[i]) begin
        if (FW'(i) > current_floor) above = 1'b1;
        if (FW'(i) < current_floor) below = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller: FSM, per-floor travel timer and door dwell timer.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS  = 8,
  parameter  int MOVE_CYCLES = 3,
  parameter  int DOOR_CYCLES = 4,
  localparam int FW          = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_req,
  output logic [FW-1:0]         current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(MOVE_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LOAD = DCW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0]  TOP_FLOOR = FW'(NUM_FLOORS - 1);

  state_t                state, state_nxt;
  logic [FW-1:0]         floor_nxt, arrive_floor, clr_floor;
  logic                  dir_nxt, clr_en;
  logic [MCW-1:0]        move_cnt, move_nxt;
  logic [DCW-1:0]        door_cnt, door_nxt;
  logic [NUM_FLOORS-1:0] req_eff;
  logic                  above, below, ahead, behind;

  elevator_req_tracker #(
    .NUM_FLOORS(NUM_FLOORS),
    .FW        (FW)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .floor_req    (floor_req),
    .current_floor(current_floor),
    .clr_en       (clr_en),
    .clr_floor    (clr_floor),
    .pending      (pending),
    .req_eff      (req_eff),
    .above        (above),
    .below        (below)
  );

  assign ahead        = (direction == DIR_UP) ? above : below;
  assign behind       = (direction == DIR_UP) ? below : above;
  assign arrive_floor = (direction == DIR_UP) ? current_floor + FW'(1) : current_floor - FW'(1);

  // Next-state, timers and serve/clear decisions
  always_comb begin
    state_nxt = state;
    floor_nxt = current_floor;
    dir_nxt   = direction;
    move_nxt  = move_cnt;
    door_nxt  = door_cnt;
    clr_en    = 1'b0;
    clr_floor = current_floor;
    case (state)
      IDLE: begin
        if (req_eff[current_floor]) begin
          state_nxt = DOOR;
          clr_en    = 1'b1;
          door_nxt  = DOOR_LOAD;
        end else if (ahead) begin
          state_nxt = MOVE;
          move_nxt  = '0;
        end else if (behind) begin
          state_nxt = MOVE;
          dir_nxt   = ~direction;
          move_nxt  = '0;
        end
      end
      MOVE: begin
        if (move_cnt == MOVE_LAST) begin
          move_nxt  = '0;
          floor_nxt = arrive_floor;
          if (req_eff[arrive_floor]) begin
            state_nxt = DOOR;
            clr_en    = 1'b1;
            clr_floor = arrive_floor;
            door_nxt  = DOOR_LOAD;
          end
        end else begin
          move_nxt = move_cnt + MCW'(1);
        end
      end
      DOOR: begin
        // A re-press of this floor only extends the dwell; never latch it
        clr_en = 1'b1;
        if (floor_req[current_floor]) begin
          door_nxt = DOOR_LOAD;
        end else if (door_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          door_nxt = door_cnt - DCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, position, direction, timers and decoded outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      current_floor <= '0;
      direction     <= DIR_UP;
      move_cnt      <= '0;
      door_cnt      <= '0;
      moving        <= 1'b0;
      door_open     <= 1'b0;
    end else begin
      state         <= state_nxt;
      current_floor <= floor_nxt;
      direction     <= dir_nxt;
      move_cnt      <= move_nxt;
      door_cnt      <= door_nxt;
      moving        <= (state_nxt == MOVE);
      door_open     <= (state_nxt == DOOR);
    end
  end

  floor_in_range: assert property (@(posedge clk) disable iff (rst)
    current_floor <= TOP_FLOOR);

  no_step_past_end: assert property (@(posedge clk) disable iff (rst)
    (state == MOVE && move_cnt == MOVE_LAST) |->
      ((direction == DIR_UP) ? (current_floor != TOP_FLOOR) : (current_floor != '0)));

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl with a floor/progress-level reference model.
module tb_elevator_scan_ctrl;

  localparam int NF = 8;
  localparam int MC = 3;
  localparam int DC = 4;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  localparam int EV_OPEN   = 0;
  localparam int EV_CLOSE  = 1;
  localparam int EV_DEPART = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] floor_req;
  logic [2:0]    current_floor;
  logic          direction, moving, door_open;
  logic [NF-1:0] pending;

  always #5 clk = ~clk;

  elevator_scan_ctrl #(
    .NUM_FLOORS (NF),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .floor_req    (floor_req),
    .current_floor(current_floor),
    .direction    (direction),
    .moving       (moving),
    .door_open    (door_open),
    .pending      (pending)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int      kind;
    int      t;
    int      fl;
    bit      dir;
    bit [7:0] pend;
  } ev_t;

  ev_t sb[$];

  // Reference model: car floor, travel progress within a floor, dwell remaining
  bit [NF-1:0] m_pend;
  int          m_fl, m_mode, m_prog, m_door;
  bit          m_dir;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    m_pend = '0; m_fl = 0; m_dir = 1'b1; m_mode = M_IDLE; m_prog = 0; m_door = 0;
    sb.delete();
  endfunction

  // Advance the model by one clock edge that samples fr
  function automatic void model_step(input bit [NF-1:0] fr);
    bit [NF-1:0] req;
    bit          up_calls, down_calls;
    int          ev;
    ev_t         e;
    req = m_pend | fr;
    ev = -1;
    up_calls = 1'b0;
    down_calls = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (req[i] && i > m_fl) up_calls = 1'b1;
      if (req[i] && i < m_fl) down_calls = 1'b1;
    end
    case (m_mode)
      M_IDLE: begin
        if (req[m_fl]) begin
          req[m_fl] = 1'b0; m_mode = M_DOOR; m_door = DC; ev = EV_OPEN;
        end else if (m_dir ? up_calls : down_calls) begin
          m_mode = M_MOVE; m_prog = 0; ev = EV_DEPART;
        end else if (m_dir ? down_calls : up_calls) begin
          m_dir = !m_dir; m_mode = M_MOVE; m_prog = 0; ev = EV_DEPART;
        end
      end
      M_MOVE: begin
        m_prog++;
        if (m_prog == MC) begin
          m_prog = 0;
          m_fl = m_fl + (m_dir ? 1 : -1);
          if (req[m_fl]) begin
            req[m_fl] = 1'b0; m_mode = M_DOOR; m_door = DC; ev = EV_OPEN;
          end
        end
      end
      default: begin
        req[m_fl] = 1'b0;
        if (fr[m_fl]) m_door = DC;
        else begin
          m_door--;
          if (m_door == 0) begin m_mode = M_IDLE; ev = EV_CLOSE; end
        end
      end
    endcase
    m_pend = req;
    if (ev >= 0) begin
      e.kind = ev; e.t = cyc + 1; e.fl = m_fl; e.dir = m_dir; e.pend = m_pend;
      sb.push_back(e);
    end
  endfunction

  task automatic tick(input bit [NF-1:0] fr);
    @(negedge clk);
    floor_req = fr;
    model_step(fr);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(m_mode == M_IDLE && m_pend == '0) && n < budget) begin
      tick('0);
      n++;
    end
    if (n >= budget) check("idle_budget", n, -1);
    repeat (3) tick('0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_floor"}, current_floor, 0);
    check({tag, "_dir"}, direction, 1);
    check({tag, "_moving"}, moving, 0);
    check({tag, "_door"}, door_open, 0);
    check({tag, "_pending"}, pending, 0);
  endtask

  // Monitor: pops an expectation whenever door_open or moving changes visibly
  bit prev_door = 1'b0;
  bit prev_mov  = 1'b0;
  initial begin
    ev_t e;
    int  k;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_door = 1'b0;
        prev_mov  = 1'b0;
      end else begin
        while (sb.size() > 0 && sb[0].t < cyc) begin
          e = sb.pop_front();
          check("missing_event_cycle", -1, e.t);
        end
        if (door_open && !prev_door)      k = EV_OPEN;
        else if (!door_open && prev_door) k = EV_CLOSE;
        else if (moving && !prev_mov)     k = EV_DEPART;
        else                              k = -1;
        if (k >= 0) begin
          if (sb.size() == 0) begin
            check("unexpected_event_kind", k, -1);
          end else begin
            e = sb.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.t);
            check("event_floor", current_floor, e.fl);
            check("event_dir", direction, e.dir);
            check("event_pending", pending, e.pend);
          end
        end
        prev_door = door_open;
        prev_mov  = moving;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    floor_req = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // No calls: the car must stay put
    repeat (20) tick('0);
    check("idle_moving", moving, 0);
    check("idle_door", door_open, 0);
    check("idle_floor", current_floor, 0);

    // Single call three floors up
    tick(8'h08);
    wait_idle(100);
    check("after_f3_floor", current_floor, 3);

    // Sweep up to 5, call for 1 arrives behind the car and is served after reversal
    tick(8'h20);
    tick('0);
    tick('0);
    tick(8'h02);
    wait_idle(150);
    check("after_sweep_floor", current_floor, 1);
    check("after_sweep_dir", direction, 0);

    // From floor 4, same-cycle calls for 4 and 0: door first, then down
    tick(8'h10);
    wait_idle(100);
    tick(8'h11);
    wait_idle(150);
    check("after_4_0_floor", current_floor, 0);

    // Re-press floor 2 during dwell cycle 2
    tick(8'h04);
    n = 0;
    while (m_mode != M_DOOR && n < 50) begin tick('0); n++; end
    if (n >= 50) check("door_budget", n, -1);
    tick('0);
    tick(8'h04);
    wait_idle(50);

    // Reset between floors 5 and 6 with calls for 7 and 0 latched
    tick(8'h80);
    n = 0;
    while (!(m_fl == 5 && m_mode == M_MOVE && m_prog == 1) && n < 100) begin tick('0); n++; end
    if (n >= 100) check("mid_move_budget", n, -1);
    tick(8'h01);
    @(posedge clk);
    #2;
    floor_req = '0;
    check("pre_reset_pending", pending, 8'h81);
    check("pre_reset_moving", moving, 1);
    check("pre_reset_floor", current_floor, 5);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) tick('0);
    check("post_reset_moving", moving, 0);
    check("post_reset_floor", current_floor, 0);
    check("post_reset_pending", pending, 0);

    // Randomized calls
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      bit [NF-1:0] fr;
      r = $urandom_range(0, 9);
      if (r == 0)      fr = NF'(1) << $urandom_range(0, NF - 1);
      else if (r == 1) fr = NF'($urandom) & NF'($urandom);
      else             fr = '0;
      tick(fr);
    end
    wait_idle(300);
    repeat (5) tick('0);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/elevator_scan_ctrl.md
# elevator_scan_ctrl

Parametrised N-floor elevator controller and next-generation successor to the 3-floor elevator FSM. Incoming floor calls are latched into a pending-request register. The controller serves them in SCAN order: it keeps its travel direction while calls remain ahead, and reverses only when none are left. The controller tracks car position internally with a per-floor travel timer and holds the door open for a timed dwell. The block sits between the call-button logic and the motor/door drivers.

## Interface
- NUM_FLOORS, 8, number of floors, must be ≥ 2; FW = max(1, clog2(NUM_FLOORS)) is local.
- MOVE_CYCLES, 3, clock cycles to travel one floor, must be ≥ 1.
- DOOR_CYCLES, 4, clock cycles the door stays open, must be ≥ 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- floor_req  in  NUM_FLOORS  call bitmask; bit i set for one or more cycles requests floor i.
- current_floor  out  FW  floor the car is at or last passed; registered.
- direction  out  1  1 = up, 0 = down; registered; holds its value while idle.
- moving  out  1  1 while the controller is in the MOVE state.
- door_open  out  1  1 while the controller is in the DOOR state.
- pending  out  NUM_FLOORS  latched, unserved calls.

## Operation
- States: IDLE, MOVE, DOOR.
- Reset values: state = IDLE, current_floor = 0, direction = 1, moving = 0, door_open = 0, pending = 0, both timers = 0.
- Request capture: req_eff = pending | floor_req. Each edge, pending ← req_eff with the served bit cleared.
- above = any req_eff bit strictly higher than current_floor. below = the same for strictly lower floors. ahead = direction ? above : below. behind is the opposite of ahead.
- IDLE, evaluated in this priority order:
  - req_eff[current_floor] set → DOOR; clear that bit; load the door timer.
  - ahead set → MOVE; direction unchanged.
  - behind set → MOVE; invert direction.
  - Otherwise stay in IDLE.
- MOVE:
  - The move timer counts 0 … MOVE_CYCLES−1.
  - At the terminal count, current_floor steps ±1 according to direction, and the timer clears.
  - On that same edge, if req_eff for the arrival floor is set → DOOR; clear the bit; load the door timer. Otherwise stay in MOVE.
- DOOR:
  - The door timer loads DOOR_CYCLES−1 and counts down. At 0 the state returns to IDLE.
  - A floor_req for current_floor while in DOOR reloads the timer and is not latched.
- Boundaries: current_floor never leaves [0, NUM_FLOORS−1]. The ahead check guarantees this; assert it.
- Calls for other floors arriving during MOVE or DOOR are latched and do not disturb the current sweep.
- Reset mid-operation drops all pending calls immediately. The car restarts as idle at floor 0.

## Timing
- Every output is registered. The state decision uses req_eff, so a call is acted on at the edge that samples it.
- Call for a floor d floors away from an idle car: moving = 1 after the sampling edge. The car arrives and door_open = 1 exactly d·MOVE_CYCLES edges later.
- A call for the current floor while idle gives door_open = 1 after the sampling edge.
- door_open stays high for exactly DOOR_CYCLES cycles when there are no re-presses. It is followed by at least one IDLE cycle before the next MOVE or DOOR.
- A pending bit clears on the same edge that door_open rises for that floor.

## Structure
- Package elevator_pkg holds:
  - the state typedef (IDLE/MOVE/DOOR, 2 bits);
  - the constants DIR_UP = 1 and DIR_DOWN = 0.
- Sub-module elevator_req_tracker holds:
  - the pending register and its set/clear logic;
  - the above/below reduction relative to current_floor.
- The FSM, the move timer and the door timer stay in the top level.

## Test plan
All scenarios use NUM_FLOORS = 8, MOVE_CYCLES = 3, DOOR_CYCLES = 4.
- Reset then idle: all outputs are zero except direction = 1. With no requests, the block stays in IDLE indefinitely.
- Idle at floor 0, pulse floor_req = 0x08: moving rises the next cycle. current_floor reads 1, 2, 3 at +3, +6, +9. door_open is high for 4 cycles starting at +9. pending[3] = 0, then IDLE.
- At floor 3 moving up with pending = {5, 1}: the car serves floor 5 first, then reverses (direction = 0) and serves floor 1.
- Idle at floor 4, floor_req = 0x10 | 0x01 in the same cycle: the door opens at floor 4 first, then the car moves down to 0.
- During DOOR at floor 2, press floor 2 again at dwell cycle 2: door_open extends to 2 + 4 cycles total, and pending[2] stays 0.
- Assert rst while moving between floors 5 and 6 with pending = 0x81: outputs return to reset values asynchronously, and no motion occurs after release.
